mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data memory: sits between the EX/MEM stage and the data memory.
- Drives the memory's word address, write data, write strobe and read strobe.
- Supports byte, halfword and word loads and stores; loads are sign- or zero-extended.
- Subword stores use a two-step read-modify-write, because the memory only writes whole words.

Parameters:
- ADDR_W, 10, word-address width driven to memory (byte address bits [ADDR_W+1:2]).
- DATA_W, 32, data width; only 32 is supported.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  1  access request; sampled only when Busy=0.
- We  in  1  1=store, 0=load.
- Size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- Sign  in  1  loads: 1=sign-extend, 0=zero-extend.
- Addr  in  32  byte address.
- Wdata  in  32  store data, right-aligned.
- Rdata  out  32  extended load result, registered.
- Done  out  1  one-cycle pulse when the access completes.
- Busy  out  1  high while an access is in flight; the pipeline stalls on it.
- AddrErr  out  1  misaligned access flag (see Optional Feature).
- MemA  out  ADDR_W  word address to memory = Addr[ADDR_W+1:2], held for the whole access.
- MemD  out  32  write data to memory.
- MemWrite  out  1  write strobe; memory writes on the rising edge.
- MemToReg  out  1  read strobe.
- MemRdata  in  32  combinational read data from memory.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - Rdata=0, Done=0, Busy=0, AddrErr=0.
  - MemWrite and MemToReg are gated by !Reset, so they are 0 immediately.
  - Reset during RMW aborts with no memory write.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- IDLE:
  - On Req&!We: go to LOAD; latch Addr, Size, Sign.
  - On Req&We&word: go to STORE; latch Addr, Wdata.
  - On Req&We&(byte|half): go to RMW_RD; latch Addr, Size, Wdata.
  - Busy=0 in IDLE. Req is ignored whenever Busy=1.
- LOAD (1 cycle):
  - MemToReg=1.
  - At the clock edge, Rdata <= extend(lane select of MemRdata).
  - Byte lane = Addr[1:0], little-endian: byte 0 = bits [7:0].
  - Half lane = Addr[1]; half 0 = bits [15:0].
  - Next state IDLE, Done=1 for the following cycle.
  - Total latency: Req accepted at edge N, Rdata valid and Done=1 after edge N+1.
- STORE (1 cycle):
  - MemWrite=1, MemD=latched Wdata; the memory writes at the exiting edge.
  - Next state IDLE, Done pulse.
  - Rdata is unchanged.
- RMW_RD (1 cycle):
  - MemToReg=1.
  - Latch MemRdata into the merge register.
- RMW_WR (1 cycle):
  - MemWrite=1.
  - MemD = merge register with the addressed byte/half lane replaced by Wdata[7:0] or Wdata[15:0].
  - Next state IDLE, Done pulse.
- Busy = (state != IDLE).
- Done is registered and asserted exactly one cycle after the final access cycle.
- Back-to-back: a new Req may be accepted in the cycle Done is high, since state is IDLE.
- MemToReg and MemWrite are never both 1 in the same cycle.
- Addresses above bit ADDR_W+1 are ignored; this wraps modulo 4 KiB.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: a half access with Addr[0]=1, or a word access with Addr[1:0]!=0, is not performed.
  - No memory strobe is issued; the FSM stays in IDLE.
  - AddrErr=1 and Done=1 for one cycle, registered, in the cycle after Req.
  - Rdata is unchanged.
- Undefined: offending low address bits are forced to zero (aligned down), the access proceeds normally, and AddrErr is tied to 0.

Decomposition:
- Shared package: Size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10) and state encodings.
- One natural sub-module: mem_lane_align.
  - Purely combinational.
  - Performs load extract/extend and store merge, given word, offset, size and sign.
  - Reused later by the cache fill path.

Test Plan:
- Store word: Addr=0x10, Wdata=0xDEADBEEF, Size=10.
  - One MemWrite cycle with MemA=4, then Done.
  - A following word load from 0x10 returns 0xDEADBEEF.
- Byte store: Addr=0x11, Wdata=0x000000AA into memory word 0x11223344.
  - RMW_RD then RMW_WR; memory word becomes 0x1122AA44.
  - Busy is high for 2 cycles.
- Loads from word 0x8000F080 at Addr 0x20:
  - Byte at 0x21, Sign=1 -> 0xFFFFFFF0.
  - Same byte, Sign=0 -> 0x000000F0.
  - Half at 0x22, Sign=1 -> 0xFFFF8000.
- Reset asserted while in RMW_RD:
  - MemWrite never rises; outputs are 0 immediately.
  - Memory word is unchanged.
- Back-to-back: Req held high across store then load.
  - Second access is accepted in the Done cycle.
  - Strobes never overlap.
- Misaligned word at 0x13:
  - With macro: AddrErr=1, Done=1, no strobes.
  - Without macro: access goes to word 0x10.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states
// and the alignment rule used by the misalignment trap.
package mem_access_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STORE  = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4
   } state_t;

   // Size must already be normalised (2'b11 folded onto SZ_WORD).
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      return ((size == SZ_HALF) && offset[0]) ||
             ((size == SZ_WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for a 32-bit little-endian word: load extract
// with sign/zero extension, and subword merge of store data into a word.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: load_data = {{24{sign & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_data = {{16{sign & half_sel[15]}}, half_sel};
         default: load_data = word;
      endcase
   end

   // Each byte lane is either kept from the word or replaced by the matching store byte.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic       hit;
         logic [7:0] src;
         always_comb begin
            case (size)
               SZ_BYTE: begin
                  hit = (offset == 2'(gi));
                  src = wdata[7:0];
               end
               SZ_HALF: begin
                  hit = (offset[1] == 1'(gi / 2));
                  src = ((gi % 2) == 1) ? wdata[15:8] : wdata[7:0];
               end
               default: begin
                  hit = 1'b1;
                  src = wdata[8*gi +: 8];
               end
            endcase
         end
         assign store_data[8*gi +: 8] = hit ? src : word[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: byte/half/word loads and stores, subword stores via read-modify-write.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them down.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic              We,
   input  logic [1:0]        Size,
   input  logic              Sign,
   input  logic [31:0]       Addr,
   input  logic [DATA_W-1:0] Wdata,
   output logic [DATA_W-1:0] Rdata,
   output logic              Done,
   output logic              Busy,
   output logic              AddrErr,
   output logic [ADDR_W-1:0] MemA,
   output logic [DATA_W-1:0] MemD,
   output logic              MemWrite,
   output logic              MemToReg,
   input  logic [DATA_W-1:0] MemRdata
);

   state_t            state_reg;
   logic [ADDR_W+1:0] addr_reg;
   logic [1:0]        size_reg;
   logic              sign_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       merge_reg;
   logic [31:0]       rdata_reg;
   logic              done_reg;
   logic [1:0]        size_norm;
   logic [1:0]        offset_in;
   logic [31:0]       load_data;
   logic [31:0]       merge_data;
   logic              unused_addr_bits;

   assign unused_addr_bits = &{1'b0, Addr[31:ADDR_W+2]};

   always_comb begin
      size_norm = (Size == 2'b11) ? SZ_WORD : Size;
      offset_in = Addr[1:0];
      if (size_norm == SZ_HALF)
         offset_in[0] = 1'b0;
      else if (size_norm == SZ_WORD)
         offset_in = 2'b00;
   end

   // Memory data is combinational, so the merged word is formed while reading and held for the write.
   mem_lane_align u_align (
      .word       (MemRdata),
      .offset     (addr_reg[1:0]),
      .size       (size_reg),
      .sign       (sign_reg),
      .wdata      (wdata_reg),
      .load_data  (load_data),
      .store_data (merge_data)
   );

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   logic addr_err_reg;
   assign AddrErr = addr_err_reg;
`else
   assign AddrErr = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         size_reg  <= SZ_WORD;
         sign_reg  <= 1'b0;
         wdata_reg <= '0;
         merge_reg <= '0;
         rdata_reg <= '0;
         done_reg  <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
         addr_err_reg <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
         addr_err_reg <= 1'b0;
`endif
         case (state_reg)
            ST_IDLE: begin
               if (Req) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                  if (is_misaligned(size_norm, Addr[1:0])) begin
                     done_reg     <= 1'b1;
                     addr_err_reg <= 1'b1;
                  end else
`endif
                  begin
                     addr_reg  <= {Addr[ADDR_W+1:2], offset_in};
                     size_reg  <= size_norm;
                     sign_reg  <= Sign;
                     wdata_reg <= Wdata;
                     if (!We)
                        state_reg <= ST_LOAD;
                     else if (size_norm == SZ_WORD)
                        state_reg <= ST_STORE;
                     else
                        state_reg <= ST_RMW_RD;
                  end
               end
            end
            ST_LOAD: begin
               rdata_reg <= load_data;
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end
            ST_STORE: begin
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end
            ST_RMW_RD: begin
               merge_reg <= merge_data;
               state_reg <= ST_RMW_WR;
            end
            ST_RMW_WR: begin
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign Rdata    = rdata_reg;
   assign Done     = done_reg;
   assign Busy     = (state_reg != ST_IDLE);
   assign MemA     = addr_reg[ADDR_W+1:2];
   assign MemD     = (state_reg == ST_RMW_WR) ? merge_reg : wdata_reg;
   assign MemWrite = !Reset && ((state_reg == ST_STORE) || (state_reg == ST_RMW_WR));
   assign MemToReg = !Reset && ((state_reg == ST_LOAD) || (state_reg == ST_RMW_RD));

endmodule
